// File: rtl/led_scan_rx_pkg.sv
// Shared seven-segment constants and enable decoding for the LED scan receiver
// and the display driver.
package led_scan_rx_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  localparam logic [5:0] ENB_DIG0  = 6'b111110;
  localparam logic [5:0] ENB_DIG1  = 6'b111101;
  localparam logic [5:0] ENB_DIG2  = 6'b111011;
  localparam logic [5:0] ENB_DIG3  = 6'b110111;
  localparam logic [5:0] ENB_DIG4  = 6'b101111;
  localparam logic [5:0] ENB_DIG5  = 6'b011111;
  localparam logic [5:0] ENB_NONE  = 6'b111111;

  typedef enum logic {ST_IDLE, ST_COLLECT} scan_state_t;

  // Returns {exactly_one_low, digit_index}; anything else yields 4'b0000.
  function automatic logic [3:0] enb_decode(input logic [5:0] enb);
    case (enb)
      ENB_DIG0: enb_decode = {1'b1, 3'd0};
      ENB_DIG1: enb_decode = {1'b1, 3'd1};
      ENB_DIG2: enb_decode = {1'b1, 3'd2};
      ENB_DIG3: enb_decode = {1'b1, 3'd3};
      ENB_DIG4: enb_decode = {1'b1, 3'd4};
      ENB_DIG5: enb_decode = {1'b1, 3'd5};
      default:  enb_decode = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder; blank decodes to F,
// unknown patterns decode to E and raise err.
module seg_to_bcd
  import led_scan_rx_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    bcd = BCD_ERR;
    err = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = BCD_BLANK;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/led_scan_rx.sv
// Receives a multiplexed six-digit seven-segment scan and republishes it as a
// complete registered frame plus BCD decode.
//
// state      | meaning
// ST_IDLE    | waiting for a digit-0 capture to start a frame
// ST_COLLECT | digits 0..exp_idx-1 held in the partial frame
module led_scan_rx
  import led_scan_rx_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [41:0] o_six_digit_seg,
  output logic [5:0]  o_six_dp,
  output logic [23:0] o_digit_bcd,
  output logic [5:0]  o_bcd_err,
  output logic        o_frame_valid,
  output logic        o_scan_err
);

  localparam logic [7:0] CAP_CNT = 8'(SETTLE - 1);

  logic [6:0] seg_s1, seg_s2;
  logic       dp_s1, dp_s2;
  logic [5:0] enb_s1, enb_s2;
  logic [7:0] stable_cnt;
  logic       armed;

  scan_state_t      state;
  logic [2:0]       exp_idx;
  logic             pub_pending;
  logic [5:0][6:0]  part_seg;
  logic [5:0][3:0]  part_bcd;
  logic [5:0]       part_dp, part_err;

  logic [3:0] enb_dec;
  logic [2:0] cap_idx;
  logic       cap_hit, cap_lit, store_en;
  logic [3:0] cap_bcd;
  logic       cap_err;

  // stable_cnt tracks how long enb_s2 has held; it clears on the same edge that
  // enb_s2 takes a new value. armed keeps the all-zero reset value of the
  // synchronizer from being mistaken for a multi-digit enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1     <= '0;
      seg_s2     <= '0;
      dp_s1      <= 1'b0;
      dp_s2      <= 1'b0;
      enb_s1     <= '0;
      enb_s2     <= '0;
      stable_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      seg_s1 <= i_seg;
      seg_s2 <= seg_s1;
      dp_s1  <= i_seg_dp;
      dp_s2  <= dp_s1;
      enb_s1 <= i_seg_enb;
      enb_s2 <= enb_s1;
      if (enb_s1 != enb_s2) begin
        stable_cnt <= '0;
        armed      <= 1'b1;
      end else if (stable_cnt != 8'hFF) begin
        stable_cnt <= stable_cnt + 8'd1;
      end
    end
  end

  assign enb_dec = enb_decode(enb_s2);
  assign cap_hit = enb_dec[3];
  assign cap_idx = enb_dec[2:0];
  assign cap_lit = armed && (stable_cnt == CAP_CNT) && (enb_s2 != ENB_NONE);

  seg_to_bcd u_dec (
    .seg (seg_s2),
    .bcd (cap_bcd),
    .err (cap_err)
  );

  // A digit-0 capture during COLLECT both flags the error and restarts the frame.
  always_comb begin
    store_en = 1'b0;
    if (cap_lit && cap_hit && !pub_pending) begin
      if (state == ST_IDLE) store_en = (cap_idx == 3'd0);
      else store_en = (cap_idx == exp_idx) || (cap_idx == exp_idx - 3'd1) ||
                      (cap_idx == 3'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      part_seg <= '0;
      part_bcd <= '0;
      part_dp  <= '0;
      part_err <= '0;
    end else if (store_en) begin
      part_seg[cap_idx] <= seg_s2;
      part_bcd[cap_idx] <= cap_bcd;
      part_dp[cap_idx]  <= dp_s2;
      part_err[cap_idx] <= cap_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      exp_idx         <= '0;
      pub_pending     <= 1'b0;
      o_six_digit_seg <= '0;
      o_six_dp        <= '0;
      o_digit_bcd     <= '0;
      o_bcd_err       <= '0;
      o_frame_valid   <= 1'b0;
      o_scan_err      <= 1'b0;
    end else begin
      o_frame_valid <= 1'b0;
      o_scan_err    <= 1'b0;
      if (pub_pending) begin
        o_six_digit_seg <= part_seg;
        o_six_dp        <= part_dp;
        o_digit_bcd     <= part_bcd;
        o_bcd_err       <= part_err;
        o_frame_valid   <= 1'b1;
        pub_pending     <= 1'b0;
        state           <= ST_IDLE;
        exp_idx         <= '0;
      end else if (cap_lit) begin
        if (!cap_hit) begin
          o_scan_err <= 1'b1;
          state      <= ST_IDLE;
          exp_idx    <= '0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (cap_idx == 3'd0) begin
                state   <= ST_COLLECT;
                exp_idx <= 3'd1;
              end
            end
            ST_COLLECT: begin
              if (cap_idx == exp_idx) begin
                exp_idx <= exp_idx + 3'd1;
                if (exp_idx == 3'd5) pub_pending <= 1'b1;
              end else if (cap_idx != exp_idx - 3'd1) begin
                o_scan_err <= 1'b1;
                if (cap_idx == 3'd0) begin
                  exp_idx <= 3'd1;
                end else begin
                  state   <= ST_IDLE;
                  exp_idx <= '0;
                end
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_scan_rx.sv
// Bench for led_scan_rx: dwell-level stimulus checked against a queue-based
// frame assembly model with predicted event cycles.
module tb_led_scan_rx;

  localparam int SETTLE = 4;
  localparam logic [6:0] PAT [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                      7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  i_seg = '0;
  logic        i_seg_dp = 1'b0;
  logic [5:0]  i_seg_enb = 6'h3F;
  logic [41:0] o_six_digit_seg;
  logic [5:0]  o_six_dp;
  logic [23:0] o_digit_bcd;
  logic [5:0]  o_bcd_err;
  logic        o_frame_valid;
  logic        o_scan_err;

  led_scan_rx #(.SETTLE(SETTLE)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_seg           (i_seg),
    .i_seg_dp        (i_seg_dp),
    .i_seg_enb       (i_seg_enb),
    .o_six_digit_seg (o_six_digit_seg),
    .o_six_dp        (o_six_dp),
    .o_digit_bcd     (o_digit_bcd),
    .o_bcd_err       (o_bcd_err),
    .o_frame_valid   (o_frame_valid),
    .o_scan_err      (o_scan_err)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  typedef struct {
    bit          is_frame;
    int          cyc;
    logic [41:0] seg;
    logic [5:0]  dp;
    logic [23:0] bcd;
    logic [5:0]  err;
  } ev_t;

  ev_t exp_q[$];
  ev_t act_q[$];

  // Model state: digits accepted so far in the current attempt, their slots,
  // and the last published frame.
  int          seq[$];
  logic [6:0]  m_seg [6];
  logic        m_dp  [6];
  logic [41:0] lf_seg = '0;
  logic [5:0]  lf_dp  = '0;
  logic [23:0] lf_bcd = '0;
  logic [5:0]  lf_err = '0;

  always @(negedge clk) begin
    ev_t e;
    if (!rst && (o_frame_valid || o_scan_err)) begin
      chk("valid_err_excl", 64'(o_frame_valid & o_scan_err), 64'd0);
      e.is_frame = o_frame_valid;
      e.cyc      = cyc;
      e.seg      = o_six_digit_seg;
      e.dp       = o_six_dp;
      e.bcd      = o_digit_bcd;
      e.err      = o_bcd_err;
      act_q.push_back(e);
    end
  end

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    if (s == 7'h00) return {1'b0, 4'hF};
    for (int d = 0; d < 10; d++) if (s == PAT[d]) return {1'b0, 4'(d)};
    return {1'b1, 4'hE};
  endfunction

  function automatic logic [5:0] enb_of(input int k);
    logic [5:0] e = 6'h3F;
    e[k] = 1'b0;
    return e;
  endfunction

  task automatic push_err(input int c);
    ev_t e;
    e.is_frame = 1'b0;
    e.cyc = c;
    e.seg = '0; e.dp = '0; e.bcd = '0; e.err = '0;
    exp_q.push_back(e);
  endtask

  task automatic model_capture(input logic [5:0] enb, input logic [6:0] seg,
                               input logic dp, input int c);
    int nl = 0;
    int idx = 0;
    ev_t e;
    for (int k = 0; k < 6; k++) if (!enb[k]) begin nl++; idx = k; end
    if (nl == 0) return;
    if (nl > 1) begin
      push_err(c);
      seq.delete();
      return;
    end
    if (seq.size() == 0) begin
      if (idx == 0) begin seq.push_back(0); m_seg[0] = seg; m_dp[0] = dp; end
      return;
    end
    if (idx == seq[$] + 1) begin
      seq.push_back(idx);
      m_seg[idx] = seg;
      m_dp[idx]  = dp;
      if (seq.size() == 6) begin
        for (int k = 0; k < 6; k++) begin
          lf_seg[7*k +: 7] = m_seg[k];
          lf_dp[k] = m_dp[k];
          {lf_err[k], lf_bcd[4*k +: 4]} = ref_decode(m_seg[k]);
        end
        e.is_frame = 1'b1;
        e.cyc = c + 1;
        e.seg = lf_seg; e.dp = lf_dp; e.bcd = lf_bcd; e.err = lf_err;
        exp_q.push_back(e);
        seq.delete();
      end
    end else if (idx == seq[$]) begin
      m_seg[idx] = seg;
      m_dp[idx]  = dp;
    end else begin
      push_err(c);
      seq.delete();
      if (idx == 0) begin seq.push_back(0); m_seg[0] = seg; m_dp[0] = dp; end
    end
  endtask

  // Applies one dwell; a dwell of at least SETTLE clocks is captured on the
  // edge SETTLE+2 clocks after it is applied.
  task automatic dwell(input logic [5:0] enb, input logic [6:0] seg,
                       input logic dp, input int len);
    i_seg_enb = enb;
    i_seg     = seg;
    i_seg_dp  = dp;
    if (len >= SETTLE) model_capture(enb, seg, dp, cyc + SETTLE + 2);
    repeat (len) begin @(posedge clk); #1; end
  endtask

  task automatic flush();
    int n;
    dwell(6'h3F, 7'h00, 1'b0, SETTLE + 6);
    chk("n_events", 64'(act_q.size()), 64'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("ev_kind", 64'(act_q[i].is_frame), 64'(exp_q[i].is_frame));
      chk("ev_cycle", 64'(act_q[i].cyc), 64'(exp_q[i].cyc));
      if (act_q[i].is_frame && exp_q[i].is_frame) begin
        chk("ev_seg", 64'(act_q[i].seg), 64'(exp_q[i].seg));
        chk("ev_dp",  64'(act_q[i].dp),  64'(exp_q[i].dp));
        chk("ev_bcd", 64'(act_q[i].bcd), 64'(exp_q[i].bcd));
        chk("ev_err", 64'(act_q[i].err), 64'(exp_q[i].err));
      end
    end
    act_q.delete();
    exp_q.delete();
    chk("hold_seg", 64'(o_six_digit_seg), 64'(lf_seg));
    chk("hold_dp",  64'(o_six_dp),        64'(lf_dp));
    chk("hold_bcd", 64'(o_digit_bcd),     64'(lf_bcd));
    chk("hold_err", 64'(o_bcd_err),       64'(lf_err));
  endtask

  task automatic model_reset();
    seq.delete();
    lf_seg = '0; lf_dp = '0; lf_bcd = '0; lf_err = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_seg"},   64'(o_six_digit_seg), 64'd0);
    chk({tag, "_dp"},    64'(o_six_dp),        64'd0);
    chk({tag, "_bcd"},   64'(o_digit_bcd),     64'd0);
    chk({tag, "_err"},   64'(o_bcd_err),       64'd0);
    chk({tag, "_valid"}, 64'(o_frame_valid),   64'd0);
    chk({tag, "_scan"},  64'(o_scan_err),      64'd0);
  endtask

  task automatic pulse_reset();
    flush();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_zero("rst");
    dwell(6'h3F, 7'h00, 1'b0, 5);
  endtask

  initial begin
    int hd;
    int sel;
    int len;
    int d;
    int a;
    int b2;
    int s;
    logic [5:0] enb;
    logic [6:0] seg;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");
    dwell(6'h3F, 7'h00, 1'b0, 5);

    // Clean "12:34:56" scan
    for (int k = 0; k < 6; k++) dwell(enb_of(k), PAT[6-k], 1'(k == 2 || k == 4), 10);
    flush();
    chk("clean_bcd", 64'(o_digit_bcd), 64'h123456);
    chk("clean_bcderr", 64'(o_bcd_err), 64'd0);

    // Undecodable digit 2
    for (int k = 0; k < 6; k++) dwell(enb_of(k), (k == 2) ? 7'h01 : PAT[k], 1'b0, 8);
    flush();
    chk("bad_nibble", 64'(o_digit_bcd[11:8]), 64'hE);
    chk("bad_bcderr", 64'(o_bcd_err), 64'b000100);

    // Out-of-order 0,1,3 then stray 4,5, then a fresh scan
    dwell(enb_of(0), PAT[9], 1'b0, 8);
    dwell(enb_of(1), PAT[8], 1'b0, 8);
    dwell(enb_of(3), PAT[7], 1'b0, 8);
    dwell(enb_of(4), PAT[6], 1'b0, 8);
    dwell(enb_of(5), PAT[5], 1'b0, 8);
    for (int k = 0; k < 6; k++) dwell(enb_of(k), PAT[k+3], 1'b1, 8);
    flush();

    // Short glitch ignored, exactly-SETTLE dwell captured, then two-low enable
    dwell(enb_of(0), PAT[1], 1'b0, 8);
    dwell(enb_of(1), PAT[2], 1'b0, 8);
    dwell(enb_of(4), PAT[9], 1'b0, SETTLE - 1);
    dwell(enb_of(2), PAT[3], 1'b0, SETTLE);
    dwell(enb_of(3), PAT[4], 1'b0, 8);
    dwell(enb_of(4), PAT[5], 1'b0, 8);
    dwell(enb_of(5), PAT[6], 1'b0, 8);
    dwell(6'b111100, PAT[0], 1'b0, 10);
    flush();

    // Repeat of digit 1 after blanking overwrites its slot
    dwell(enb_of(0), PAT[0], 1'b0, 8);
    dwell(enb_of(1), PAT[1], 1'b0, 8);
    dwell(6'h3F, 7'h00, 1'b0, 6);
    dwell(enb_of(1), PAT[7], 1'b1, 8);
    for (int k = 2; k < 6; k++) dwell(enb_of(k), PAT[k], 1'b0, 8);
    flush();
    chk("repeat_slot1", 64'(o_six_digit_seg[13:7]), 64'(PAT[7]));

    // Reset after digit 3, then 4,5 must not publish
    for (int k = 0; k < 4; k++) dwell(enb_of(k), PAT[k], 1'b0, 8);
    pulse_reset();
    dwell(enb_of(4), PAT[4], 1'b0, 8);
    dwell(enb_of(5), PAT[5], 1'b0, 8);
    flush();
    for (int k = 0; k < 6; k++) dwell(enb_of(k), PAT[9-k], 1'b0, 8);
    flush();

    // Reset landing on the publish clock suppresses the frame
    for (int k = 0; k < 5; k++) dwell(enb_of(k), PAT[k], 1'b0, 8);
    i_seg_enb = enb_of(5);
    i_seg     = PAT[5];
    repeat (SETTLE + 2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_seg_enb = 6'h3F;
    i_seg     = 7'h00;
    model_reset();
    check_zero("pubrst");
    dwell(6'h3F, 7'h00, 1'b0, 5);
    flush();

    // Randomized dwells, biased toward in-order scans
    hd = 0;
    for (int b = 0; b < 5; b++) begin
      for (int r = 0; r < 60; r++) begin
        sel = $urandom_range(0, 99);
        len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, SETTLE - 1)
                                          : $urandom_range(SETTLE, 12);
        d = hd;
        if (sel < 60) begin
          enb = enb_of(hd);
        end else if (sel < 72) begin
          enb = 6'h3F;
        end else if (sel < 88) begin
          d = $urandom_range(0, 5);
          enb = enb_of(d);
        end else begin
          a  = $urandom_range(0, 5);
          b2 = (a + $urandom_range(1, 5)) % 6;
          enb = 6'($urandom);
          enb[a]  = 1'b0;
          enb[b2] = 1'b0;
        end
        if (enb == i_seg_enb) enb = (i_seg_enb == 6'h3F) ? enb_of(0) : 6'h3F;
        s = $urandom_range(0, 19);
        seg = (s < 15) ? PAT[$urandom_range(0, 9)] : ((s < 17) ? 7'h00 : 7'($urandom));
        if (sel < 88 && sel >= 72 && len >= SETTLE) hd = (d + 1) % 6;
        if (sel < 60 && len >= SETTLE) hd = (hd + 1) % 6;
        dwell(enb, seg, 1'($urandom), len);
      end
      flush();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/led_scan_rx.md
LED_SCAN_RX -- requirements
Module: led_scan_rx

Interface
REQ-001 SHALL have parameter SETTLE, default 4, meaning the number of consecutive stable clocks of the enable bus before a digit is sampled (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock (50 MHz), sole clock of the block.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port i_seg  input  7  segment bus {a,b,c,d,e,f,g}, 1 = lit.
REQ-005 SHALL have port i_seg_dp  input  1  decimal point of the currently enabled digit.
REQ-006 SHALL have port i_seg_enb  input  6  common-node enables, active-low; bit k low selects digit k.
REQ-007 SHALL have port o_six_digit_seg  output  42  last complete frame; digit k occupies bits [7k+6:7k].
REQ-008 SHALL have port o_six_dp  output  6  last complete frame decimal points; bit k is digit k.
REQ-009 SHALL have port o_digit_bcd  output  24  decoded frame; digit k occupies bits [4k+3:4k].
REQ-010 SHALL have port o_bcd_err  output  6  bit k set when digit k of the last frame is an undecodable pattern.
REQ-011 SHALL have port o_frame_valid  output  1  one-clock pulse when a new frame is published.
REQ-012 SHALL have port o_scan_err  output  1  one-clock pulse on a scan-sequence violation.

Function
REQ-013 SHALL register i_seg, i_seg_dp and i_seg_enb through two flop stages before any use.
REQ-014 SHALL count clocks for which the synchronized enable is unchanged; the count SHALL restart at 0 on any change and saturate at 255.
REQ-015 SHALL sample the synchronized i_seg/i_seg_dp exactly once per dwell, on the clock the count reaches SETTLE-1; input-to-capture latency is therefore 2+SETTLE clocks.
REQ-016 Enable 6'b111111 (blanking) SHALL produce no capture and no error.
REQ-017 An enable with two or more low bits that reaches SETTLE-1 SHALL pulse o_scan_err, capture nothing, and return the FSM to IDLE.
REQ-018 SHALL implement FSM states IDLE and COLLECT, with a 3-bit expected index exp.
REQ-019 In IDLE, a capture of digit 0 SHALL go to COLLECT with exp=1; a capture of any other digit SHALL be ignored silently.
REQ-020 In COLLECT, a capture of digit exp SHALL store into slot exp and increment exp.
REQ-021 In COLLECT, a capture of digit exp-1 (repeat after blanking) SHALL overwrite that slot without error.
REQ-022 In COLLECT, any other capture SHALL pulse o_scan_err and discard the partial frame; a digit 0 capture SHALL then restart with exp=1, any other digit SHALL return to IDLE.
REQ-023 A capture of digit 5 with exp=5 SHALL, on the following clock, update all frame outputs simultaneously, pulse o_frame_valid, and return to IDLE.
REQ-024 Frame outputs SHALL hold their values between publications.
REQ-025 Decoding SHALL map patterns 7E,30,6D,79,33,5B,5F,70,7F,73 (hex) to BCD 0..9.
REQ-026 Pattern 00 SHALL decode to 4'hF (blank) with no error.
REQ-027 Every other pattern SHALL decode to 4'hE and set the corresponding o_bcd_err bit.
REQ-028 o_scan_err and o_frame_valid SHALL never assert in the same clock.

Reset
REQ-029 While rst=1 at a clk edge: all outputs 0, synchronizer flops 0, stable count 0, FSM IDLE, exp 0, partial frame discarded.
REQ-030 Reset asserted mid-frame SHALL suppress any pending o_frame_valid.

Structure
REQ-031 The segment pattern constants (digits 0..9, blank), BCD codes F/E and the six active-low enable codes SHALL live in a shared package, also used by the display driver.
REQ-032 Pattern-to-BCD decoding SHALL be one combinational sub-module, seg_to_bcd, instantiated once per slot or once on the capture path.

Verification
REQ-033 Clean scan 0..5 with patterns for "12:34:56" (digit5..0 = 1,2,3,4,5,6), dwell 10 clocks, SETTLE=4 -> one o_frame_valid pulse; o_digit_bcd=24'h123456; o_bcd_err=0.
REQ-034 Digit 2 pattern 7'h01 -> o_digit_bcd[11:8]=4'hE; o_bcd_err=6'b000100; frame still published.
REQ-035 Order 0,1,3 -> o_scan_err pulses at the digit-3 capture; no frame until a fresh 0..5 sequence completes.
REQ-036 Enable glitch lasting 3 clocks with SETTLE=4 -> no capture for the glitch value; enable 6'b111100 held for 10 clocks -> o_scan_err pulse.
REQ-037 rst pulsed after digit 3 is captured, then digits 4,5 supplied -> no frame and outputs remain 0; next full scan publishes normally.
REQ-038 Scan 0,1,blank,1,2,3,4,5 -> no error; one frame with the second digit-1 value.
